// File: rtl/fir_avg_pkg.sv
// fir_avg_pkg
//   Shared constants and types for the multi-channel moving-average filter.
//   W_DEF / LOG2N_DEF / CH_DEF : default sample width, window log2, channel count
//   acc_width()                : accumulator width needed for a 2^log2n window
//   acc_def_t                  : signed accumulator type for the default parameters
package fir_avg_pkg;

  localparam int W_DEF     = 24;
  localparam int LOG2N_DEF = 4;
  localparam int CH_DEF    = 2;

  // Sum of 2^log2n signed w-bit samples fits in w+log2n signed bits.
  function automatic int acc_width(input int w, input int log2n);
    return w + log2n;
  endfunction

  localparam int ACC_W_DEF = acc_width(W_DEF, LOG2N_DEF);

  typedef logic signed [ACC_W_DEF-1:0] acc_def_t;

endpackage

// File: rtl/fir_avg_delay_line.sv
// fir_avg_delay_line
//   N-entry ring buffer of packed multi-channel samples, shared by all channels.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset (buffer and pointer to zero)
//   clr    : synchronous clear of buffer and pointer (takes priority over we)
//   we     : write din at the current pointer and advance the pointer
//   din    : CH*W packed samples to store
//   oldest : CH*W packed entry at the write pointer, i.e. the sample leaving
//            the window on the next write (combinational)
module fir_avg_delay_line
  import fir_avg_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LOG2N = LOG2N_DEF,
  parameter int CH    = CH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            we,
  input  logic [CH*W-1:0] din,
  output logic [CH*W-1:0] oldest
);

  localparam int N = 1 << LOG2N;

  logic [CH*W-1:0]  mem_q [N];
  logic [CH*W-1:0]  mem_d [N];
  logic [LOG2N-1:0] ptr_q;
  logic [LOG2N-1:0] ptr_d;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (clr) begin
      for (int i = 0; i < N; i++) mem_d[i] = '0;
      ptr_d = '0;
    end else if (we) begin
      mem_d[ptr_q] = din;
      // N is a power of two, so the natural wrap of the pointer is modulo N.
      ptr_d        = ptr_q + LOG2N'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

  assign oldest = mem_q[ptr_q];

endmodule

// File: rtl/fir_avg_multi.sv
// fir_avg_multi
//   Multi-channel boxcar (moving-average) filter over the last 2^LOG2N
//   accepted samples, all channels advancing in lockstep.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   isValid  : sample strobe, dataIn accepted on a rising edge while high
//   flush    : synchronous clear of window, accumulators and fill count;
//              wins over a simultaneous isValid (that sample is dropped)
//   bypass   : 1 = output the accepted sample unfiltered, 0 = window average
//   dataIn   : CH*W packed signed samples, channel c at [c*W +: W]
//   dataOut  : CH*W packed registered outputs, same packing
//   outValid : one-cycle pulse following each accepted sample
//   filled   : high once N samples have been accepted since reset/flush
module fir_avg_multi
  import fir_avg_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LOG2N = LOG2N_DEF,
  parameter int CH    = CH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            isValid,
  input  logic            flush,
  input  logic            bypass,
  input  logic [CH*W-1:0] dataIn,
  output logic [CH*W-1:0] dataOut,
  output logic            outValid,
  output logic            filled
);

  localparam int N  = 1 << LOG2N;
  localparam int AW = acc_width(W, LOG2N);

  // Arithmetic shift floors toward minus infinity; the average of W-bit
  // samples always fits back into W bits, so truncation is lossless.
  function automatic logic signed [W-1:0] avg_of(input logic signed [AW-1:0] sum);
    logic signed [AW-1:0] q;
    q = sum >>> LOG2N;
    return q[W-1:0];
  endfunction

  logic            accept;
  logic [CH*W-1:0] oldest;

  logic [LOG2N:0]  fill_q;
  logic [LOG2N:0]  fill_d;
  logic            filled_p1_q;
  logic            filled_p1_d;
  logic            vld_p1_q;
  logic            vld_p1_d;

  assign accept = isValid & ~flush;

  // Stage p0: window storage and the sample about to leave it
  fir_avg_delay_line #(
    .W     (W),
    .LOG2N (LOG2N),
    .CH    (CH)
  ) u_delay_line (
    .clk    (clk),
    .reset  (reset),
    .clr    (flush),
    .we     (accept),
    .din    (dataIn),
    .oldest (oldest)
  );

  always_comb begin
    fill_d   = fill_q;
    vld_p1_d = accept;
    if (flush) begin
      fill_d = '0;
    end else if (accept && (fill_q != (LOG2N+1)'(N))) begin
      fill_d = fill_q + (LOG2N+1)'(1);
    end
    filled_p1_d = (fill_d == (LOG2N+1)'(N));
  end

  // Stage p1: registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q      <= '0;
      filled_p1_q <= 1'b0;
      vld_p1_q    <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      filled_p1_q <= filled_p1_d;
      vld_p1_q    <= vld_p1_d;
    end
  end

  assign outValid = vld_p1_q;
  assign filled   = filled_p1_q;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [W-1:0]  smp_p0;
    logic signed [W-1:0]  old_p0;
    logic signed [AW-1:0] acc_nxt_p0;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [W-1:0]  dout_p1_q;
    logic signed [W-1:0]  dout_p1_d;

    assign smp_p0 = dataIn[c*W +: W];
    assign old_p0 = oldest[c*W +: W];

    // Stage p0: running sum with the incoming sample in and the oldest out
    always_comb begin
      acc_nxt_p0 = acc_q + AW'(smp_p0) - AW'(old_p0);
      acc_d      = acc_q;
      dout_p1_d  = dout_p1_q;
      if (flush) begin
        acc_d     = '0;
        dout_p1_d = '0;
      end else if (accept) begin
        acc_d     = acc_nxt_p0;
        dout_p1_d = bypass ? smp_p0 : avg_of(acc_nxt_p0);
      end
    end

    // Stage p1: registered accumulator and channel output
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q     <= '0;
        dout_p1_q <= '0;
      end else begin
        acc_q     <= acc_d;
        dout_p1_q <= dout_p1_d;
      end
    end

    assign dataOut[c*W +: W] = dout_p1_q;
  end

endmodule

// File: tb/tb_fir_avg_multi.sv
module tb_fir_avg_multi;

  localparam int W     = 24;
  localparam int LOG2N = 4;
  localparam int CH    = 2;
  localparam int N     = 1 << LOG2N;

  logic            clk = 1'b0;
  logic            reset;
  logic            isValid;
  logic            flush;
  logic            bypass;
  logic [CH*W-1:0] dataIn;
  logic [CH*W-1:0] dataOut;
  logic            outValid;
  logic            filled;

  fir_avg_multi #(.W(W), .LOG2N(LOG2N), .CH(CH)) dut (
    .clk      (clk),
    .reset    (reset),
    .isValid  (isValid),
    .flush    (flush),
    .bypass   (bypass),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .outValid (outValid),
    .filled   (filled)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the list of accepted samples since reset/flush,
  // averaged with floor division.
  int hist0[$];
  int hist1[$];
  int exp_out0;
  int exp_out1;
  bit exp_vld;
  bit exp_filled;
  int acc_cnt;

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int window_avg(input int q[$]);
    int s;
    s = 0;
    for (int i = 0; i < q.size(); i++) s += q[i];
    return floor_div(s, N);
  endfunction

  function automatic int ch_out(input int c);
    logic [W-1:0] v;
    v = dataOut[c*W +: W];
    return int'($signed(v));
  endfunction

  function automatic int rand_smp();
    logic [W-1:0] r;
    r = W'($urandom);
    return int'($signed(r));
  endfunction

  task automatic model_clear();
    hist0.delete();
    hist1.delete();
    exp_out0   = 0;
    exp_out1   = 0;
    exp_vld    = 1'b0;
    exp_filled = 1'b0;
    acc_cnt    = 0;
  endtask

  task automatic model_step(input bit v, input bit fl, input bit byp, input int s0, input int s1);
    if (fl) begin
      model_clear();
    end else if (v) begin
      hist0.push_back(s0);
      hist1.push_back(s1);
      if (hist0.size() > N) void'(hist0.pop_front());
      if (hist1.size() > N) void'(hist1.pop_front());
      exp_out0   = byp ? s0 : window_avg(hist0);
      exp_out1   = byp ? s1 : window_avg(hist1);
      exp_vld    = 1'b1;
      acc_cnt++;
      exp_filled = (acc_cnt >= N);
    end else begin
      exp_vld = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the model; outputs are
  // then stable 1 time unit after the edge.
  task automatic cycle(input bit v, input bit fl, input bit byp, input int s0, input int s1);
    isValid = v;
    flush   = fl;
    bypass  = byp;
    dataIn  = {W'(s1), W'(s0)};
    @(posedge clk);
    #1;
    model_step(v, fl, byp, s0, s1);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    isValid = 1'b0;
    flush   = 1'b0;
    bypass  = 1'b0;
    dataIn  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    checks++;
    if (dataOut !== '0 || outValid !== 1'b0 || filled !== 1'b0) begin
      failures++;
      $display("FAIL reset got dataOut=%h vld=%b filled=%b want 0 0 0", dataOut, outValid, filled);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 160, -160);
      checks++;
      if (ch_out(0) !== 10*(i+1) || ch_out(1) !== -10*(i+1) || outValid !== 1'b1 ||
          filled !== (i == N-1)) begin
        failures++;
        $display("FAIL ramp[%0d] got ch0=%0d ch1=%0d vld=%b filled=%b want ch0=%0d ch1=%0d vld=1 filled=%b",
                 i, ch_out(0), ch_out(1), outValid, filled, 10*(i+1), -10*(i+1), (i == N-1));
      end
    end
  endtask

  task automatic test_steady();
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 320, -160);
      checks++;
      if (ch_out(0) !== exp_out0 || ch_out(1) !== exp_out1 || outValid !== exp_vld || filled !== exp_filled ||
          (i < 4 && ch_out(0) !== 170 + 10*i) || (i == N-1 && ch_out(0) !== 320)) begin
        failures++;
        $display("FAIL steady[%0d] got ch0=%0d ch1=%0d vld=%b filled=%b want ch0=%0d ch1=%0d vld=%b filled=%b",
                 i, ch_out(0), ch_out(1), outValid, filled, exp_out0, exp_out1, exp_vld, exp_filled);
      end
    end
  endtask

  task automatic test_floor();
    int sv [4];
    int wv [4];
    sv = '{-1, 0, -15, -1};
    wv = '{-1, -1, -1, -2};
    cycle(1'b0, 1'b1, 1'b0, 0, 0);
    checks++;
    if (dataOut !== '0 || outValid !== 1'b0 || filled !== 1'b0) begin
      failures++;
      $display("FAIL floor_flush got dataOut=%h vld=%b filled=%b want 0 0 0", dataOut, outValid, filled);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, sv[i], rand_smp());
      checks++;
      if (ch_out(0) !== wv[i] || ch_out(0) !== exp_out0 || ch_out(1) !== exp_out1 || outValid !== 1'b1) begin
        failures++;
        $display("FAIL floor[%0d] got ch0=%0d ch1=%0d vld=%b want ch0=%0d ch1=%0d vld=1",
                 i, ch_out(0), ch_out(1), outValid, wv[i], exp_out1);
      end
    end
  endtask

  task automatic test_gaps_bypass();
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cycle(pat[i], 1'b0, 1'b0, rand_smp(), rand_smp());
      checks++;
      if (ch_out(0) !== exp_out0 || ch_out(1) !== exp_out1 || outValid !== pat[i] || filled !== exp_filled) begin
        failures++;
        $display("FAIL gap[%0d] got ch0=%0d ch1=%0d vld=%b filled=%b want ch0=%0d ch1=%0d vld=%b filled=%b",
                 i, ch_out(0), ch_out(1), outValid, filled, exp_out0, exp_out1, pat[i], exp_filled);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 1000, -1000);
    checks++;
    if (ch_out(0) !== 1000 || ch_out(1) !== -1000 || outValid !== 1'b1) begin
      failures++;
      $display("FAIL bypass got ch0=%0d ch1=%0d vld=%b want ch0=1000 ch1=-1000 vld=1",
               ch_out(0), ch_out(1), outValid);
    end
    cycle(1'b1, 1'b0, 1'b0, 1000, -1000);
    checks++;
    if (ch_out(0) !== exp_out0 || ch_out(1) !== exp_out1 || outValid !== 1'b1 || filled !== exp_filled) begin
      failures++;
      $display("FAIL unbypass got ch0=%0d ch1=%0d vld=%b filled=%b want ch0=%0d ch1=%0d vld=1 filled=%b",
               ch_out(0), ch_out(1), outValid, filled, exp_out0, exp_out1, exp_filled);
    end
  endtask

  task automatic test_flush_collision();
    for (int i = 0; i < N; i++) cycle(1'b1, 1'b0, 1'b0, 160, 160);
    checks++;
    if (filled !== 1'b1 || ch_out(0) !== 160) begin
      failures++;
      $display("FAIL coll_full got ch0=%0d filled=%b want ch0=160 filled=1", ch_out(0), filled);
    end
    cycle(1'b1, 1'b1, 1'b0, 999, 999);
    checks++;
    if (dataOut !== '0 || outValid !== 1'b0 || filled !== 1'b0) begin
      failures++;
      $display("FAIL coll_flush got dataOut=%h vld=%b filled=%b want 0 0 0", dataOut, outValid, filled);
    end
    cycle(1'b1, 1'b0, 1'b0, 160, 160);
    checks++;
    if (ch_out(0) !== 10 || ch_out(1) !== 10 || outValid !== 1'b1 || filled !== 1'b0) begin
      failures++;
      $display("FAIL coll_next got ch0=%0d ch1=%0d vld=%b filled=%b want 10 10 1 0",
               ch_out(0), ch_out(1), outValid, filled);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, rand_smp(), rand_smp());
    reset = 1'b1;
    #2;
    checks++;
    if (dataOut !== '0 || outValid !== 1'b0 || filled !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got dataOut=%h vld=%b filled=%b want 0 0 0", dataOut, outValid, filled);
    end
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 160, -160);
      checks++;
      if (ch_out(0) !== exp_out0 || ch_out(1) !== exp_out1 || filled !== (i == N-1) ||
          (i == 0 && ch_out(0) !== 10)) begin
        failures++;
        $display("FAIL resume[%0d] got ch0=%0d ch1=%0d filled=%b want ch0=%0d ch1=%0d filled=%b",
                 i, ch_out(0), ch_out(1), filled, exp_out0, exp_out1, (i == N-1));
      end
    end
  endtask

  task automatic test_random();
    bit v;
    bit fl;
    bit byp;
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      byp = ($urandom_range(0, 4) == 0);
      cycle(v, fl, byp, rand_smp(), rand_smp());
      checks++;
      if (ch_out(0) !== exp_out0 || ch_out(1) !== exp_out1 || outValid !== exp_vld || filled !== exp_filled) begin
        failures++;
        $display("FAIL random[%0d] got ch0=%0d ch1=%0d vld=%b filled=%b want ch0=%0d ch1=%0d vld=%b filled=%b",
                 i, ch_out(0), ch_out(1), outValid, filled, exp_out0, exp_out1, exp_vld, exp_filled);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    isValid = 1'b0;
    flush   = 1'b0;
    bypass  = 1'b0;
    dataIn  = '0;
    model_clear();
    test_reset();
    test_ramp();
    test_steady();
    test_floor();
    test_gaps_bypass();
    test_flush_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_avg_multi.md
Name: fir_avg_multi

Overview:
Parametrised multi-channel moving-average (boxcar FIR) filter: the successor of the single-channel audio averaging filter.
- Averages the last 2^LOG2N accepted samples per channel using a shared ring buffer and running accumulators.
- Adds a per-sample output-valid strobe, a window-filled flag, synchronous flush and a bypass mode.
- Sits between the audio CODEC input path and the output path, filtering all channels (default: stereo L/R) in lockstep.

Parameters:
W, 24, sample width in bits (signed two's complement) per channel
LOG2N, 4, log2 of window depth; window N = 2^LOG2N samples (1..8 supported)
CH, 2, number of parallel channels

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
isValid  input  1  sample strobe; dataIn accepted on any rising edge where high
flush  input  1  synchronous clear of window, accumulators and fill count
bypass  input  1  1: dataOut passes accepted input unfiltered; 0: filtered average
dataIn  input  CH*W  packed samples, channel c at bits [c*W +: W]
dataOut  output  CH*W  packed registered outputs, same packing
outValid  output  1  high exactly one cycle after each accepted sample
filled  output  1  high once N samples have been accepted since reset/flush

Behaviour:
- Reset (async, active-high): ring buffer all zero, write pointer 0, accumulators 0, fill count 0, dataOut 0, outValid 0, filled 0.
- Accepted sample: isValid=1 and flush=0 at a rising edge. For each channel c:
  - oldest = buf[wr_ptr][c] (combinational read).
  - acc_next = acc + dataIn[c] - oldest.
  - buf[wr_ptr][c] <= dataIn[c]; acc <= acc_next.
  - dataOut[c] <= bypass ? dataIn[c] : acc_next >>> LOG2N.
- wr_ptr increments modulo N and wraps from N-1 to 0 with no gap.
- Width rules:
  - Accumulator is signed W+LOG2N bits and cannot overflow.
  - The shift is arithmetic, so negative values floor (-1 → -1, -17 → -2).
  - The result is truncated to W bits and is always in range.
- Latency is one cycle: outValid=1 in the cycle after the accepting edge, otherwise 0. dataOut holds its last value when there is no acceptance.
- Prefill: the buffer starts at zero, so the output is partial_sum/N (ramp-up). No special divisor is applied.
- Fill count saturates at N. filled rises on the edge that accepts the Nth sample, so filled and the first full-window outValid are coincident.
- Bypass: the accumulator and buffer still update, so toggling bypass never corrupts the window. Bypass is sampled per accepted sample.
- flush=1 at an edge:
  - Clears buffer, accumulators, wr_ptr, fill count, filled and dataOut.
  - Drives outValid=0.
  - flush has priority over a simultaneous isValid; that sample is dropped.
- isValid gaps of any length are allowed; state is frozen during gaps.
- reset asserted mid-operation: all state returns to reset values immediately (async). Accepting resumes on the first edge after deassertion.

Decomposition:
- Package fir_avg_pkg holds:
  - default constants W_DEF=24, LOG2N_DEF=4, CH_DEF=2;
  - function acc_width(w, log2n) = w+log2n;
  - typedef of the signed accumulator for default parameters.
- One sub-module, fir_avg_delay_line:
  - N-entry × (CH*W) ring buffer with write pointer, write enable, synchronous clear and combinational oldest-entry read.
  - Instantiated once and shared across channels.
- Per-channel accumulate/shift logic is a generate loop in the top.

Test Plan:
1. Defaults. Reset, then 16 accepted samples, ch0=160, ch1=-160 → ch0 dataOut ramps 10,20,…,160 and ch1 ramps -10,…,-160. outValid is high one cycle after each acceptance. filled rises with the 16th output.
2. Steady state at 160/-160, then 4 samples of ch0=320 → ch0 outputs 170,180,190,200 (sum 3200/16). Further 12 samples of 320 → ch0 reaches 320 and holds.
3. Negative floor: after flush, a single ch0=-1 sample → dataOut ch0 = -1. Then 0 → -1 (sum -1). Then -15 → -1 (sum -16 → -1). Then -1 → -2 (sum -17 → floor -2).
4. Gaps and bypass: isValid toggled 1,0,0,1 → outValid pulses only after accepted edges and dataOut holds between them. Then bypass=1 with input 1000 → dataOut=1000. Then bypass=0 with input 1000 → filtered value consistent with the uninterrupted window.
5. Flush collision: window full at 160, flush=1 and isValid=1 with 999 on the same edge → dataOut=0, outValid=0, filled=0. Next accepted 160 → 10 (999 never entered the window).
6. Async reset mid-stream: assert reset between edges → outputs zero immediately, without a clock edge. Resume with 160 → 10, and filled stays low until 16 more samples.
